// File: rtl/sequencer_pkg.sv
// Shared types and default encodings for the instruction sequencer and SM-side decode.
package sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StIssue,
      StDone,
      StPause
   } seq_state_e;

   localparam logic [14:0] DefaultNop  = 15'h0000;
   localparam logic [14:0] DefaultHalt = 15'h7FFF;

   // Counter width able to hold ISSUE_CYCLES-1 with headroom for the zero flag.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/issue_counter.sv
// Loadable down-counter with a zero flag; times how long an instruction is held.
module issue_counter
   import sequencer_pkg::*;
#(
   parameter int unsigned ISSUE_CYCLES = 3,
   localparam int unsigned CntWidth = cnt_width(ISSUE_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                load,
   input  logic [CntWidth-1:0] load_value,
   input  logic                dec,
   output logic                zero
);

   logic [CntWidth-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - CntWidth'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches SM instructions from a synchronous RAM and holds each on `instruction`.
// Optional single-step mode: define INSTRUCTION_SEQUENCER_STEP_EN to add `step` and PAUSE.
module instruction_sequencer
   import sequencer_pkg::*;
#(
   parameter int unsigned INSTRUCTION_WIDTH = 15,
   parameter int unsigned PC_WIDTH = 8,
   parameter int unsigned ISSUE_CYCLES = 3,
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = INSTRUCTION_WIDTH'(DefaultNop),
   parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR = INSTRUCTION_WIDTH'(DefaultHalt)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
   input  logic                         step,
`endif
   input  logic [PC_WIDTH-1:0]          base_pc,
   output logic [PC_WIDTH-1:0]          instr_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_q,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         issue_valid,
   output logic                         busy,
   output logic                         done,
   output logic [PC_WIDTH-1:0]          pc
);

   localparam int unsigned CntWidth = cnt_width(ISSUE_CYCLES);
   localparam logic [CntWidth-1:0] IssueLoad = CntWidth'(ISSUE_CYCLES - 1);

   seq_state_e state;
   logic       is_halt;
   logic       cnt_zero;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_clear;

   always_comb begin
      is_halt   = (instr_q == HALT_INSTR);
      cnt_load  = (state == StLoad) && !abort && !is_halt;
      cnt_dec   = (state == StIssue) && !abort && !cnt_zero;
      cnt_clear = abort && (state != StIdle);
   end

   assign instr_addr = pc;

   issue_counter #(
      .ISSUE_CYCLES(ISSUE_CYCLES)
   ) u_issue_counter (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clear),
      .load      (cnt_load),
      .load_value(IssueLoad),
      .dec       (cnt_dec),
      .zero      (cnt_zero)
   );

   // Outputs are registered alongside the state so they track it cycle for cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         pc          <= '0;
         instruction <= NOP_INSTR;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  pc    <= base_pc;
                  busy  <= 1'b1;
                  state <= StFetch;
               end
            end
            StFetch: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  state <= StLoad;
               end
            end
            StLoad: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (is_halt) begin
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  instruction <= instr_q;
                  issue_valid <= 1'b1;
                  pc          <= pc + PC_WIDTH'(1);
                  state       <= StIssue;
               end
            end
            StIssue: begin
               if (abort) begin
                  instruction <= NOP_INSTR;
                  issue_valid <= 1'b0;
                  busy        <= 1'b0;
                  state       <= StIdle;
               end else if (cnt_zero) begin
                  instruction <= NOP_INSTR;
                  issue_valid <= 1'b0;
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
                  state       <= StPause;
`else
                  state       <= StFetch;
`endif
               end
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
            StPause: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (step) begin
                  state <= StFetch;
               end
            end
`endif
            default: begin
               instruction <= NOP_INSTR;
               issue_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench: expected per-cycle output traces are derived from the RAM program contents.
module tb_instruction_sequencer;

   localparam int unsigned IW = 15;
   localparam int unsigned PW = 8;
   localparam int unsigned IC = 3;
   localparam logic [IW-1:0] NOP = 15'h0000;
   localparam logic [IW-1:0] HALT = 15'h7FFF;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [PW-1:0] base_pc;
   logic [PW-1:0] instr_addr;
   logic [IW-1:0] instr_q;
   logic [IW-1:0] instruction;
   logic          issue_valid;
   logic          busy;
   logic          done;
   logic [PW-1:0] pc;
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
   logic          step;
`endif

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instruction_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
      .step       (step),
`endif
      .base_pc    (base_pc),
      .instr_addr (instr_addr),
      .instr_q    (instr_q),
      .instruction(instruction),
      .issue_valid(issue_valid),
      .busy       (busy),
      .done       (done),
      .pc         (pc)
   );

   logic [IW-1:0] mem [256];
   always @(posedge clk) instr_q <= mem[instr_addr];

   typedef struct packed {
      logic [IW-1:0] instr;
      logic          valid;
      logic          busy;
      logic          done;
      logic [PW-1:0] pc;
   } exp_t;

   exp_t trace[$];

   function automatic exp_t mk(input logic [IW-1:0] i, input logic v, input logic b,
                               input logic d, input logic [PW-1:0] p);
      exp_t e;
      e.instr = i;
      e.valid = v;
      e.busy  = b;
      e.done  = d;
      e.pc    = p;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cycle(input string tag, input exp_t e);
      check({tag, ".instruction"}, 32'(instruction), 32'(e.instr));
      check({tag, ".issue_valid"}, 32'(issue_valid), 32'(e.valid));
      check({tag, ".busy"}, 32'(busy), 32'(e.busy));
      check({tag, ".done"}, 32'(done), 32'(e.done));
      check({tag, ".pc"}, 32'(pc), 32'(e.pc));
      check({tag, ".instr_addr"}, 32'(instr_addr), 32'(e.pc));
   endtask

   // Expected outputs for every cycle after start is taken, ending with one idle cycle.
   task automatic build_trace(input logic [PW-1:0] base);
      logic [PW-1:0] a;
      a = base;
      trace.delete();
      for (int n = 0; n < 300; n++) begin
         trace.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, a));
         trace.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, a));
         if (mem[a] == HALT) begin
            trace.push_back(mk(NOP, 1'b0, 1'b1, 1'b1, a));
            trace.push_back(mk(NOP, 1'b0, 1'b0, 1'b0, a));
            break;
         end
         for (int k = 0; k < int'(IC); k++) trace.push_back(mk(mem[a], 1'b1, 1'b1, 1'b0, a + 8'd1));
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
         trace.push_back(mk(NOP, 1'b0, 1'b1, 1'b0, a + 8'd1));
`endif
         a = a + 8'd1;
      end
   endtask

   // mode 0: run to HALT; 1: abort in cycle cut; 2: reset in cycle cut. noise: stray starts.
   task automatic run(input string tag, input logic [PW-1:0] base, input int mode, input int cut,
                      input bit noise);
      int c;
      logic [PW-1:0] pc_after;
      build_trace(base);
      c = cut % (trace.size() - 1);
      start = 1'b1;
      base_pc = base;
      tick();
      start = 1'b0;
      base_pc = PW'($urandom);
      for (int t = 0; t < trace.size(); t++) begin
         check_cycle(tag, trace[t]);
         if (mode != 0 && t == c) begin
            if (mode == 1) abort = 1'b1;
            else reset = 1'b1;
            pc_after = (mode == 1) ? trace[t].pc : '0;
            tick();
            abort = 1'b0;
            reset = 1'b0;
            check_cycle({tag, ".after"}, mk(NOP, 1'b0, 1'b0, 1'b0, pc_after));
            return;
         end
         if (noise && trace[t].busy) begin
            start = 1'($urandom_range(0, 1));
            base_pc = ($urandom_range(0, 1) == 1) ? 8'd40 : PW'($urandom);
         end
         tick();
         start = 1'b0;
      end
   endtask

   task automatic load_random_program(input logic [PW-1:0] base);
      int len;
      logic [IW-1:0] v;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
         v = IW'($urandom);
         if (v == HALT) v = 15'h0001;
         mem[base + PW'(i)] = v;
      end
      mem[base + PW'(len)] = HALT;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = HALT;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      base_pc = '0;
`ifdef INSTRUCTION_SEQUENCER_STEP_EN
      step = 1'b1;
`endif
      tick();
      tick();
      reset = 1'b0;
      check_cycle("reset", mk(NOP, 1'b0, 1'b0, 1'b0, 8'd0));
      tick();

      mem[0] = 15'h1000;
      mem[1] = 15'h2000;
      mem[2] = HALT;
      run("prog", 8'd0, 0, 0, 1'b0);
      run("abort_issue2", 8'd0, 1, 3, 1'b0);
      run("abort_load", 8'd0, 1, 1, 1'b0);

      mem[8'hFF] = 15'h0A0A;
      mem[0] = HALT;
      run("wrap", 8'hFF, 0, 0, 1'b0);

      mem[8'h10] = 15'h1234;
      mem[8'h11] = HALT;
      run("reset_issue", 8'h10, 2, 2, 1'b0);
      mem[5] = 15'h0555;
      mem[6] = HALT;
      run("after_reset", 8'd5, 0, 0, 1'b0);

      mem[8'h30] = 15'h0111;
      mem[8'h31] = 15'h0222;
      mem[8'h32] = 15'h0333;
      mem[8'h33] = HALT;
      run("start_busy", 8'h30, 0, 0, 1'b1);

      for (int r = 0; r < 40; r++) begin
         logic [PW-1:0] b;
         b = PW'($urandom);
         load_random_program(b);
         run("rand", b, $urandom_range(0, 2), $urandom_range(0, 40), 1'b1);
      end

`ifdef INSTRUCTION_SEQUENCER_STEP_EN
      mem[8'h20] = 15'h1000;
      mem[8'h21] = 15'h2000;
      mem[8'h22] = HALT;
      step = 1'b0;
      start = 1'b1;
      base_pc = 8'h20;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      for (int i = 0; i < 4; i++) begin
         check_cycle("pause", mk(NOP, 1'b0, 1'b1, 1'b0, 8'h21));
         tick();
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step.fetch_addr", 32'(instr_addr), 32'h21);
      tick();
      tick();
      check("step.issue", 32'(instruction), 32'h2000);
      step = 1'b1;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("step.finish_busy", 32'(busy), 32'd0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
